// File: rtl/pong_pkg.sv
// Shared definitions for the pong game: state codes, default geometry and the
// paddle-zone velocity table applied when the ball bounces off a paddle.
package pong_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SERVE     = 3'd1;
  localparam logic [2:0] ST_PLAY      = 3'd2;
  localparam logic [2:0] ST_PAUSED    = 3'd3;
  localparam logic [2:0] ST_POINT     = 3'd4;
  localparam logic [2:0] ST_GAME_OVER = 3'd5;

  localparam int DEF_FRAME_WIDTH   = 640;
  localparam int DEF_FRAME_HEIGHT  = 480;
  localparam int DEF_PADDLE_HEIGHT = 80;
  localparam int DEF_PADDLE_WIDTH  = 8;
  localparam int DEF_BALL_SIZE     = 8;
  localparam int DEF_PADDLE_STEP   = 4;

  typedef struct packed {
    logic [2:0] dx;
    logic [1:0] dy;
    logic       down;
  } zone_vel_t;

  // Outer zones deflect steeply, the centre zone returns the ball flat and fast.
  function automatic zone_vel_t zone_vel(input logic [2:0] zone);
    zone_vel_t v;
    case (zone)
      3'd0:    v = '{dx: 3'd2, dy: 2'd2, down: 1'b0};
      3'd1:    v = '{dx: 3'd3, dy: 2'd1, down: 1'b0};
      3'd3:    v = '{dx: 3'd3, dy: 2'd1, down: 1'b1};
      3'd4:    v = '{dx: 3'd2, dy: 2'd2, down: 1'b1};
      default: v = '{dx: 3'd4, dy: 2'd0, down: 1'b0};
    endcase
    return v;
  endfunction

endpackage

// File: rtl/paddle_ctrl.sv
// Converts encoder up/down pulses into a clamped paddle top coordinate.
module paddle_ctrl #(
  parameter int FRAME_HEIGHT  = 480,
  parameter int PADDLE_HEIGHT = 80,
  parameter int PADDLE_STEP   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        up,
  input  logic        down,
  output logic [11:0] y
);

  localparam logic [11:0]        Y_INIT = 12'((FRAME_HEIGHT - PADDLE_HEIGHT) / 2);
  localparam logic signed [12:0] Y_MAX  = 13'(FRAME_HEIGHT - PADDLE_HEIGHT);
  localparam logic signed [12:0] STEP   = 13'(PADDLE_STEP);

  logic signed [12:0] y_up, y_dn;
  logic [11:0]        y_d;

  always_comb begin
    y_up = $signed({1'b0, y}) - STEP;
    y_dn = $signed({1'b0, y}) + STEP;
    y_d  = y;
    if (enable && up && !down) begin
      y_d = (y_up < 13'sd0) ? 12'd0 : y_up[11:0];
    end else if (enable && down && !up) begin
      y_d = (y_dn > Y_MAX) ? Y_MAX[11:0] : y_dn[11:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) y <= Y_INIT;
    else       y <= y_d;
  end

endmodule

// File: rtl/pong_game_fsm.sv
// Pong game controller: serve/play/point sequencing, ball motion with wall and
// paddle bounces, scoring and win detection. Ball moves only on frame_tick.
module pong_game_fsm import pong_pkg::*; #(
  parameter int FRAME_WIDTH   = DEF_FRAME_WIDTH,
  parameter int FRAME_HEIGHT  = DEF_FRAME_HEIGHT,
  parameter int PADDLE_HEIGHT = DEF_PADDLE_HEIGHT,
  parameter int PADDLE_WIDTH  = DEF_PADDLE_WIDTH,
  parameter int BALL_SIZE     = DEF_BALL_SIZE,
  parameter int P1_X          = 16,
  parameter int P2_X          = FRAME_WIDTH - 16 - PADDLE_WIDTH,
  parameter int PADDLE_STEP   = DEF_PADDLE_STEP,
  parameter int WIN_SCORE     = 9,
  parameter int SERVE_DELAY   = 60
) (
  input  logic        CLOCK_25,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        p1_up,
  input  logic        p1_down,
  input  logic        p2_up,
  input  logic        p2_down,
  input  logic        start,
  input  logic        pause,
  output logic [11:0] ball_x,
  output logic [11:0] ball_y,
  output logic [11:0] p1_y,
  output logic [11:0] p2_y,
  output logic [3:0]  score_p1,
  output logic [3:0]  score_p2,
  output logic [2:0]  state,
  output logic [1:0]  winner
);

  localparam logic [11:0]        CX       = 12'((FRAME_WIDTH - BALL_SIZE) / 2);
  localparam logic [11:0]        CY       = 12'((FRAME_HEIGHT - BALL_SIZE) / 2);
  localparam logic signed [12:0] FW       = 13'(FRAME_WIDTH);
  localparam logic signed [12:0] FH       = 13'(FRAME_HEIGHT);
  localparam logic signed [12:0] BS       = 13'(BALL_SIZE);
  localparam logic signed [12:0] HALF_BS  = 13'(BALL_SIZE / 2);
  localparam logic signed [12:0] PH       = 13'(PADDLE_HEIGHT);
  localparam logic signed [12:0] ZONE_H   = 13'(PADDLE_HEIGHT / 5);
  localparam logic signed [12:0] FACE1    = 13'(P1_X + PADDLE_WIDTH);
  localparam logic signed [12:0] FACE2    = 13'(P2_X - BALL_SIZE);
  localparam logic [15:0]        CNT_LAST = 16'(SERVE_DELAY - 1);
  localparam logic [3:0]         WIN      = 4'(WIN_SCORE);

  logic [11:0] ball_x_d, ball_y_d;
  logic [3:0]  score_p1_d, score_p2_d;
  logic [2:0]  state_d, dx, dx_d;
  logic [1:0]  winner_d, dy, dy_d;
  logic        dir_x, dir_x_d, dir_y, dir_y_d;
  logic [15:0] cnt, cnt_d;

  logic signed [12:0] bx, by, p1s, p2s, vx, vy, nx, ny, nx_w, ny_w, off, zq;
  logic               hit1, hit2, tick_done, paddle_en;
  logic [2:0]         zone;
  zone_vel_t          zv;

  assign paddle_en = (state == ST_SERVE) || (state == ST_PLAY);

  paddle_ctrl #(
    .FRAME_HEIGHT (FRAME_HEIGHT),
    .PADDLE_HEIGHT(PADDLE_HEIGHT),
    .PADDLE_STEP  (PADDLE_STEP)
  ) u_paddle1 (
    .clk   (CLOCK_25),
    .reset (reset),
    .enable(paddle_en),
    .up    (p1_up),
    .down  (p1_down),
    .y     (p1_y)
  );

  paddle_ctrl #(
    .FRAME_HEIGHT (FRAME_HEIGHT),
    .PADDLE_HEIGHT(PADDLE_HEIGHT),
    .PADDLE_STEP  (PADDLE_STEP)
  ) u_paddle2 (
    .clk   (CLOCK_25),
    .reset (reset),
    .enable(paddle_en),
    .up    (p2_up),
    .down  (p2_down),
    .y     (p2_y)
  );

  // Candidate ball step, collision and deflection zone, from pre-update paddles.
  always_comb begin
    bx   = $signed({1'b0, ball_x});
    by   = $signed({1'b0, ball_y});
    p1s  = $signed({1'b0, p1_y});
    p2s  = $signed({1'b0, p2_y});
    vx   = $signed({10'd0, dx});
    vy   = $signed({11'd0, dy});
    nx   = dir_x ? bx + vx : bx - vx;
    ny   = dir_y ? by + vy : by - vy;
    hit1 = !dir_x && (bx >= FACE1) && (nx <= FACE1) && (by + BS > p1s) && (by < p1s + PH);
    hit2 = dir_x && (bx <= FACE2) && (nx >= FACE2) && (by + BS > p2s) && (by < p2s + PH);
    off  = by + HALF_BS - (dir_x ? p2s : p1s);
    zq   = off / ZONE_H;
    if (off < 13'sd0)      zone = 3'd0;
    else if (zq > 13'sd4)  zone = 3'd4;
    else                   zone = zq[2:0];
    zv = zone_vel(zone);
  end

  always_comb begin
    state_d    = state;
    ball_x_d   = ball_x;
    ball_y_d   = ball_y;
    dx_d       = dx;
    dy_d       = dy;
    dir_x_d    = dir_x;
    dir_y_d    = dir_y;
    score_p1_d = score_p1;
    score_p2_d = score_p2;
    winner_d   = winner;
    cnt_d      = cnt;
    nx_w       = nx;
    ny_w       = ny;
    tick_done  = frame_tick && (cnt == CNT_LAST);

    case (state)
      ST_IDLE, ST_GAME_OVER: begin
        if (start) begin
          state_d    = ST_SERVE;
          score_p1_d = '0;
          score_p2_d = '0;
          winner_d   = '0;
          ball_x_d   = CX;
          ball_y_d   = CY;
          dx_d       = 3'd4;
          dy_d       = '0;
          dir_x_d    = 1'b1;
          dir_y_d    = 1'b0;
          cnt_d      = '0;
        end
      end
      ST_SERVE, ST_POINT: begin
        if (tick_done) begin
          cnt_d = '0;
          if (state == ST_SERVE) begin
            state_d = ST_PLAY;
          end else if (score_p1 >= WIN) begin
            state_d  = ST_GAME_OVER;
            winner_d = 2'd1;
          end else if (score_p2 >= WIN) begin
            state_d  = ST_GAME_OVER;
            winner_d = 2'd2;
          end else begin
            state_d = ST_SERVE;
          end
        end else if (frame_tick) begin
          cnt_d = cnt + 16'd1;
        end
      end
      ST_PAUSED: begin
        if (start) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (pause) begin
          state_d = ST_PAUSED;
        end else if (frame_tick) begin
          if (ny <= 13'sd0) begin
            ny_w    = '0;
            dir_y_d = 1'b1;
          end else if (ny + BS >= FH) begin
            ny_w    = FH - BS;
            dir_y_d = 1'b0;
          end
          if (hit1 || hit2) begin
            nx_w    = hit1 ? FACE1 : FACE2;
            dir_x_d = hit1;
            dx_d    = zv.dx;
            dy_d    = zv.dy;
            dir_y_d = zv.down;
          end
          if (nx_w <= 13'sd0 || nx_w + BS >= FW) begin
            // Point scored: recentre and aim the next serve at the player who missed.
            if (nx_w <= 13'sd0) score_p2_d = score_p2 + 4'd1;
            else                score_p1_d = score_p1 + 4'd1;
            dir_x_d  = (nx_w > 13'sd0);
            state_d  = ST_POINT;
            ball_x_d = CX;
            ball_y_d = CY;
            dx_d     = 3'd4;
            dy_d     = '0;
            cnt_d    = '0;
          end else begin
            ball_x_d = nx_w[11:0];
            ball_y_d = ny_w[11:0];
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_25) begin
    if (reset) begin
      state    <= ST_IDLE;
      ball_x   <= CX;
      ball_y   <= CY;
      dx       <= 3'd4;
      dy       <= '0;
      dir_x    <= 1'b1;
      dir_y    <= 1'b0;
      score_p1 <= '0;
      score_p2 <= '0;
      winner   <= '0;
      cnt      <= '0;
    end else begin
      state    <= state_d;
      ball_x   <= ball_x_d;
      ball_y   <= ball_y_d;
      dx       <= dx_d;
      dy       <= dy_d;
      dir_x    <= dir_x_d;
      dir_y    <= dir_y_d;
      score_p1 <= score_p1_d;
      score_p2 <= score_p2_d;
      winner   <= winner_d;
      cnt      <= cnt_d;
    end
  end

endmodule

// File: doc/pong_game_fsm.md
PONG_GAME_FSM -- requirements
Module: pong_game_fsm

Interface
REQ-001 Parameter FRAME_WIDTH, default 640: playfield width in pixels.
REQ-002 Parameter FRAME_HEIGHT, default 480: playfield height in pixels.
REQ-003 Parameter PADDLE_HEIGHT, default 80, multiple of 5: paddle height.
REQ-004 Parameter PADDLE_WIDTH, default 8; BALL_SIZE, default 8; P1_X, default 16: paddle 1 left edge; P2_X, default FRAME_WIDTH-16-PADDLE_WIDTH.
REQ-005 Parameter PADDLE_STEP, default 4: pixels per paddle pulse.
REQ-006 Parameter WIN_SCORE, default 9, range 1..15: points to win.
REQ-007 Parameter SERVE_DELAY, default 60: frame ticks spent in SERVE and POINT.
REQ-008 CLOCK_25  in  1  sole clock; reset  in  1  synchronous, active-high.
REQ-009 frame_tick  in  1  one-cycle pulse per frame; sole ball-update strobe.
REQ-010 p1_up, p1_down, p2_up, p2_down  in  1 each  one-cycle encoder pulses.
REQ-011 start  in  1  leaves IDLE/PAUSED/GAME_OVER; pause  in  1  requests pause from PLAY.
REQ-012 ball_x, ball_y  out  12 each  ball top-left; p1_y, p2_y  out  12 each  paddle top.
REQ-013 score_p1, score_p2  out  4 each; state  out  3  FSM state; winner  out  2  (0 none, 1 P1, 2 P2).

Function
REQ-014 States IDLE, SERVE, PLAY, PAUSED, POINT, GAME_OVER; all transitions on CLOCK_25 edge.
REQ-015 IDLE: start=1 -> SERVE, scores cleared, ball centred, velocity dx=4 dy=0 rightward.
REQ-016 SERVE/POINT: count SERVE_DELAY frame_ticks, ball held at centre; then SERVE -> PLAY, POINT -> SERVE or GAME_OVER.
REQ-017 PLAY: pause=1 -> PAUSED (priority over ball update same cycle); PAUSED: start=1 -> PLAY, positions frozen.
REQ-018 PLAY, frame_tick: ball_x +/- dx, ball_y +/- dy, dx in 1..4, dy in 0..3, direction bits separate.
REQ-019 Wall: next ball_y <= 0 -> ball_y=0, direction down; next ball_y+BALL_SIZE >= FRAME_HEIGHT -> ball_y=FRAME_HEIGHT-BALL_SIZE, direction up.
REQ-020 Paddle hit: leftward ball crossing P1_X+PADDLE_WIDTH (rightward crossing P2_X-BALL_SIZE) with vertical overlap (ball_y+BALL_SIZE > py and ball_y < py+PADDLE_HEIGHT) -> ball_x clamped to paddle face, x-direction reversed.
REQ-021 Zone = clamp((ball_y+BALL_SIZE/2-py)/(PADDLE_HEIGHT/5), 0, 4); zone 0: dx2 dy2 up; 1: dx3 dy1 up; 2: dx4 dy0; 3: dx3 dy1 down; 4: dx2 dy2 down.
REQ-022 Miss: next ball_x <= 0 -> score_p2+1; next ball_x+BALL_SIZE >= FRAME_WIDTH -> score_p1+1; state -> POINT; next serve dx4 dy0 toward conceding player.
REQ-023 Score reaching WIN_SCORE: POINT delay elapses -> GAME_OVER, winner set; start=1 -> SERVE with scores cleared, winner=0.
REQ-024 Paddles move only in SERVE and PLAY: up -> py-PADDLE_STEP clamped to 0; down -> clamped to FRAME_HEIGHT-PADDLE_HEIGHT; up and down same cycle -> no move.
REQ-025 Arithmetic in 13 bits signed before clamping; no wrap-around of any coordinate.
REQ-026 Ball and paddle update in same cycle: collision uses pre-update paddle position.

Reset
REQ-027 reset=1: state IDLE, ball_x=(FRAME_WIDTH-BALL_SIZE)/2 (316), ball_y=(FRAME_HEIGHT-BALL_SIZE)/2 (236), p1_y=p2_y=(FRAME_HEIGHT-PADDLE_HEIGHT)/2 (200), scores 0, winner 0, counters 0.
REQ-028 reset overrides every input in any state, including mid-POINT and mid-PLAY.

Structure
REQ-029 Shared package pong_pkg holds state enumeration, zone velocity table, default geometry constants.
REQ-030 Sub-module paddle_ctrl (pulse-to-position with clamping) instantiated twice.

Verification
REQ-031 Reset, start, 60 ticks -> state PLAY; next tick ball_x 320, ball_y 236.
REQ-032 Ball dy2 up at ball_y 1 -> next tick ball_y 0, direction down, next tick ball_y 2.
REQ-033 p1_y 200, ball centre at 244 crossing paddle 1 face -> zone 2, dx4 dy0 rightward, ball_x 24.
REQ-034 p1_y 0 with p1_up pulse -> p1_y 0; p1_up and p1_down same cycle -> p1_y unchanged.
REQ-035 Paddle 1 at 0, ball at y 400 reaching x 0 -> score_p2 1, state POINT; 60 ticks later SERVE, ball moving left.
REQ-036 score_p1 8, P1 scores -> GAME_OVER, winner 1; reset during POINT -> IDLE, all outputs per REQ-027.
